// File: rtl/universal_shift_register.sv
// Universal shift register: direct hold/shift/rotate/load/clear operations plus
// a multi-step shift/rotate burst with a start/busy/done handshake.
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ModeHold = 3'd0;
  localparam logic [2:0] ModeShr  = 3'd1;
  localparam logic [2:0] ModeShl  = 3'd2;
  localparam logic [2:0] ModeRor  = 3'd3;
  localparam logic [2:0] ModeRol  = 3'd4;
  localparam logic [2:0] ModeLoad = 3'd5;
  localparam logic [2:0] ModeClr  = 3'd6;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       bmode_q, bmode_d;

  // One operation step on the register value; serial inputs are taken live.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic             sl,
                                                input logic             sr,
                                                input logic [WIDTH-1:0] ld);
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      ModeHold: res = cur;
      ModeShr:  res = {sl, cur[WIDTH-1:1]};
      ModeShl:  res = {cur[WIDTH-2:0], sr};
      ModeRor:  res = {cur[0], cur[WIDTH-1:1]};
      ModeRol:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeLoad: res = ld;
      ModeClr:  res = '0;
      default:  res = cur;
    endcase
    return res;
  endfunction

  logic burst_mode;
  assign burst_mode = (mode >= ModeShr) && (mode <= ModeRol);

  // Next-state: direct operations in idle, latched-mode stepping while running.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    bmode_d = bmode_q;
    unique case (state_q)
      StIdle: begin
        if (start && burst_mode) begin
          // q is left untouched on the accepting edge
          bmode_d = mode;
          rem_d   = amount;
          state_d = (amount != '0) ? StRun : StDone;
        end else begin
          q_d = apply_op(mode, q_q, sin_l, sin_r, pdata_in);
        end
      end
      StRun: begin
        q_d   = apply_op(bmode_q, q_q, sin_l, sin_r, pdata_in);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= '0;
      rem_q   <= '0;
      bmode_q <= ModeHold;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      bmode_q <= bmode_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: expected {q, busy, done} is
// queued when stimulus is applied and popped/compared after the clock edge.
module tb_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] pdata_in;
  logic       start;
  logic [3:0] amount;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  logic [7:0] rol3 [3] = '{8'h4B, 8'h96, 8'h2D};
  logic [7:0] shl4 [4] = '{8'h4A, 8'h94, 8'h28, 8'h50};
  logic [7:0] ror8 [8] = '{8'h28, 8'h14, 8'h0A, 8'h05, 8'h82, 8'h41, 8'hA0, 8'h50};

  universal_shift_register #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .pdata_in(pdata_in),
    .start   (start),
    .amount  (amount),
    .q       (q),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".q"}, q, e.q);
    check({tag, ".sout_l"}, {7'd0, sout_l}, {7'd0, e.q[7]});
    check({tag, ".sout_r"}, {7'd0, sout_r}, {7'd0, e.q[0]});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
    check({tag, ".done"}, {7'd0, done}, {7'd0, e.done});
  endtask

  // Queue the expectation, clock once, then pop and compare just after the edge.
  task automatic step(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    sb.push_back('{q: eq, busy: eb, done: ed});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty observed=%h expected=entry", tag, q);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    mode     = 3'd0;
    sin_l    = 1'b0;
    sin_r    = 1'b0;
    pdata_in = 8'h00;
    start    = 1'b0;
    amount   = 4'd0;
    #3;
    check_all("reset", '{q: 8'h00, busy: 1'b0, done: 1'b0});
    #9 rst_n = 1'b1;

    // Direct load, shift right, rotate left.
    mode = 3'd5; pdata_in = 8'hA5;
    step("load_a5", 8'hA5, 1'b0, 1'b0);
    mode = 3'd1; sin_l = 1'b1;
    step("shr", 8'hD2, 1'b0, 1'b0);
    mode = 3'd4; sin_l = 1'b0;
    step("rol_direct", 8'hA5, 1'b0, 1'b0);

    // Burst rotate left by 3.
    start = 1'b1; mode = 3'd4; amount = 4'd3;
    step("rol3_accept", 8'hA5, 1'b1, 1'b0);
    start = 1'b0; mode = 3'd0;
    for (int i = 0; i < 3; i++) step("rol3_step", rol3[i], (i < 2), (i == 2));
    step("rol3_idle", 8'h2D, 1'b0, 1'b0);

    // Reload, then burst shift left by 4 with zero fill.
    mode = 3'd5; pdata_in = 8'hA5;
    step("reload", 8'hA5, 1'b0, 1'b0);
    start = 1'b1; mode = 3'd2; amount = 4'd4; sin_r = 1'b0;
    step("shl4_accept", 8'hA5, 1'b1, 1'b0);
    start = 1'b0; mode = 3'd0;
    for (int i = 0; i < 4; i++) step("shl4_step", shl4[i], (i < 3), (i == 3));
    step("shl4_idle", 8'h50, 1'b0, 1'b0);

    // Rotate right by WIDTH returns the original value.
    start = 1'b1; mode = 3'd3; amount = 4'd8;
    step("ror8_accept", 8'h50, 1'b1, 1'b0);
    start = 1'b0; mode = 3'd0;
    for (int i = 0; i < 8; i++) step("ror8_step", ror8[i], (i < 7), (i == 7));
    step("ror8_idle", 8'h50, 1'b0, 1'b0);

    // Zero-length burst: done without busy, q unchanged.
    start = 1'b1; mode = 3'd1; amount = 4'd0; sin_l = 1'b1;
    step("amt0_done", 8'h50, 1'b0, 1'b1);
    start = 1'b0; mode = 3'd0;
    step("amt0_idle", 8'h50, 1'b0, 1'b0);

    // start with a non-burst mode is a plain load.
    start = 1'b1; mode = 3'd5; pdata_in = 8'h3C;
    step("start_load", 8'h3C, 1'b0, 1'b0);
    start = 1'b0; mode = 3'd0;
    step("start_load_hold", 8'h3C, 1'b0, 1'b0);

    // Burst of 6 with ignored control churn, live serial input, aborted by reset.
    start = 1'b1; mode = 3'd1; amount = 4'd6; sin_l = 1'b0;
    step("b6_accept", 8'h3C, 1'b1, 1'b0);
    start = 1'b1; mode = 3'd5; pdata_in = 8'hFF; amount = 4'd1;
    step("b6_step1", 8'h1E, 1'b1, 1'b0);
    mode = 3'd6; sin_l = 1'b1;
    step("b6_step2", 8'h8F, 1'b1, 1'b0);
    start = 1'b0; mode = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    check_all("abort_reset", '{q: 8'h00, busy: 1'b0, done: 1'b0});
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("post_abort", 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised universal shift register; next generation of the bidirectional serial register.
- Adds parallel load, clear, rotate in both directions, and both serial ends exposed.
- Adds a multi-step burst command: shift or rotate by N positions, with a start/busy/done handshake.
- Used as a general data-path shifter and serialiser/deserialiser in lab designs.

Parameters:
WIDTH, 8, register width in bits (≥2)
CNT_W, 4, width of the burst amount field; bursts of up to 2^CNT_W-1 steps

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  3  operation select (encoding below)
sin_l  input  1  serial input entering at MSB on right shift
sin_r  input  1  serial input entering at LSB on left shift
pdata_in  input  WIDTH  parallel load data
start  input  1  burst request (shift/rotate modes only)
amount  input  CNT_W  burst step count
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1], combinational
sout_r  output  1  q[0], combinational
busy  output  1  high while a burst is stepping
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset: rst_n low forces, asynchronously, q=0, state=IDLE, busy=0, done=0, remaining count=0. Reset mid-burst aborts the burst; no done pulse is issued.
- mode encoding:
  - 000 hold
  - 001 shift right: q <= {sin_l, q[W-1:1]}
  - 010 shift left: q <= {q[W-2:0], sin_r}
  - 011 rotate right
  - 100 rotate left
  - 101 parallel load q <= pdata_in
  - 110 clear
  - 111 hold (reserved)
- FSM states: IDLE, RUN, DONE.
- IDLE, start=0: mode is applied at every rising edge (direct operation).
- IDLE, start=1, mode in 001..100:
  - Latch mode and amount; q is unchanged at that edge.
  - amount≠0: go to RUN.
  - amount=0: go directly to DONE; busy never asserts.
- IDLE, start=1, mode not in 001..100: start is ignored and mode executes as a direct operation. No busy, no done.
- RUN:
  - Exactly one step of the latched mode per edge.
  - sin_l/sin_r are sampled live at each step.
  - remaining is decremented per step. The edge performing the last step moves the FSM to DONE.
- DONE: lasts one cycle, then returns to IDLE. q holds during DONE.
- busy = (state==RUN); done = (state==DONE). Both are registered-state decodes.
- Timing: start sampled at edge k with amount N>0 gives:
  - steps at edges k+1..k+N;
  - busy high from edge k to edge k+N;
  - done high from edge k+N to edge k+N+1, with the final q visible in that cycle.
- During RUN and DONE, mode, start, amount and pdata_in are ignored.
- A new start is accepted in the first IDLE cycle after DONE.
- amount is honoured literally, including values ≥ WIDTH. A rotate by WIDTH returns the original value; a shift by ≥ WIDTH fills the register with serial input.
- sout_l and sout_r always track q with no added latency.

Test Plan:
- Reset, then mode=101, pdata_in=8'hA5, one edge -> q=8'hA5, sout_l=1, sout_r=1, busy=0, done=0.
- From A5: mode=001, sin_l=1, one edge -> q=8'hD2. Then mode=100 with no start, one edge -> q=8'hA5.
- From A5: start=1, mode=100, amount=3 -> q steps 4B, 96, 2D on consecutive edges; busy high for 3 cycles; done high exactly 1 cycle with q=8'h2D.
- From A5: start, mode=010, amount=4, sin_r=0 -> q=8'h50 at done. Then start, mode=011, amount=8 -> q returns to 8'h50.
- start with amount=0 -> busy stays 0, done pulses 1 cycle on the next edge, q unchanged. start with mode=101 -> plain load, no done.
- Burst amount=6 in progress, toggle mode/start/pdata_in -> no effect on q. Then drive rst_n low at step 3 -> q=0, busy=0 immediately; no done pulse after rst_n is released.
